// File: rtl/icache_controller.sv
// ---------------------------------------------------------------------------
// icache_controller
//
// Purpose:
//   Direct-mapped instruction cache (8 lines x 16 bytes) with a miss
//   sequencer that sits between the CPU fetch stage and a 1 KiB
//   block-organised instruction memory.
//   - A hit returns the selected 32-bit word in the same cycle.
//   - A miss stalls the CPU, reads the whole block from memory, fills the
//     line, and then serves the fetch.
//   - Saturating counters record fetch hits and misses.
//
// Ports:
//   clock         in   system clock; all state updates on posedge
//   reset         in   synchronous active-high reset
//   read          in   CPU fetch request
//   address       in   CPU byte address: tag [9:7], index [6:4], word [3:2]
//   instruction   out  fetched word; valid when read=1 and busywait=0
//   busywait      out  stall to the CPU
//   mem_read      out  block read request to instruction memory
//   mem_address   out  block address {tag,index}
//   mem_readinst  in   128-bit block from memory; byte k at [8k+7:8k]
//   mem_busywait  in   memory busy; low when mem_readinst is valid
//   hit_count     out  saturating fetch-hit count since reset
//   miss_count    out  saturating miss count since reset
// ---------------------------------------------------------------------------
module icache_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             read,
    input  logic [9:0]       address,
    output logic [31:0]      instruction,
    output logic             busywait,
    output logic             mem_read,
    output logic [5:0]       mem_address,
    input  logic [127:0]     mem_readinst,
    input  logic             mem_busywait,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_valid;
    logic [2:0]         r_tag  [8];
    logic [127:0]       r_data [8];
    logic [2:0]         r_req_tag;
    logic [2:0]         r_req_index;
    logic               r_mem_read;
    logic [CNT_W-1:0]   r_hit_count;
    logic [CNT_W-1:0]   r_miss_count;

    logic [2:0]         w_tag;
    logic [2:0]         w_index;
    logic [1:0]         w_word;
    logic               w_hit;
    logic [127:0]       w_line;
    logic               w_unused;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_tag    = address[9:7];
    assign w_index  = address[6:4];
    assign w_word   = address[3:2];
    // Byte offset within the word is irrelevant for 32-bit fetches.
    assign w_unused = &{1'b0, address[1:0]};

    assign w_line = r_data[w_index];
    assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_comb begin
        instruction = w_line[31:0];
        case (w_word)
            2'd0: instruction = w_line[31:0];
            2'd1: instruction = w_line[63:32];
            2'd2: instruction = w_line[95:64];
            2'd3: instruction = w_line[127:96];
            default: instruction = w_line[31:0];
        endcase
    end

    // Outside IDLE the CPU is always stalled; in IDLE only a missing fetch
    // stalls, so the re-lookup after a fill releases the CPU immediately.
    always_comb begin
        busywait = 1'b1;
        if (r_state == IDLE)
            busywait = read && !w_hit;
    end

    // The latched request drives the memory, so the CPU address may wander
    // while the fill is outstanding.
    assign mem_read    = r_mem_read;
    assign mem_address = {r_req_tag, r_req_index};
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;

    // Tag and data arrays are deliberately left out of reset; the valid bits
    // alone guard them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_req_tag    <= '0;
            r_req_index  <= '0;
            r_mem_read   <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (read) begin
                        if (w_hit) begin
                            r_hit_count <= sat_inc(r_hit_count);
                        end else begin
                            r_req_tag    <= w_tag;
                            r_req_index  <= w_index;
                            r_miss_count <= sat_inc(r_miss_count);
                            r_mem_read   <= 1'b1;
                            r_state      <= MEM_READ;
                        end
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        r_mem_read <= 1'b0;
                        r_state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_data[r_req_index]  <= mem_readinst;
                    r_tag[r_req_index]   <= r_req_tag;
                    r_valid[r_req_index] <= 1'b1;
                    r_state              <= IDLE;
                end
                default: begin
                    r_mem_read <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// ---------------------------------------------------------------------------
// tb_icache_controller
//
// Self-checking bench for icache_controller. A behavioural instruction
// memory with programmable latency answers block reads; a reference model of
// the cache predicts hit/miss, stall length, returned word and counters.
// Expected fetch results are queued when a fetch is driven and popped when
// the DUT releases busywait.
// ---------------------------------------------------------------------------
module tb_icache_controller;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             read;
    logic [9:0]       address;
    logic [31:0]      instruction;
    logic             busywait;
    logic             mem_read;
    logic [5:0]       mem_address;
    logic [127:0]     mem_readinst;
    logic             mem_busywait;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    icache_controller #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clock = ~clock;

    // Behavioural memory: busy for mem_lat cycles of an active read.
    int mem_lat = 0;
    int mem_cnt = 0;

    function automatic logic [31:0] memword(input logic [5:0] b, input logic [1:0] w);
        return {w, b, 8'h5A, w, b, ~w, ~b};
    endfunction

    always @(posedge clock) begin
        if (!mem_read)
            mem_cnt <= 0;
        else
            mem_cnt <= mem_cnt + 1;
    end

    assign mem_busywait = mem_read && (mem_cnt < mem_lat);

    always_comb begin
        mem_readinst = '0;
        for (int k = 0; k < 4; k++)
            mem_readinst[32*k +: 32] = memword(mem_address, 2'(k));
    end

    // Reference model and scoreboard.
    typedef struct {
        logic [31:0] instr;
        int          stall;
    } exp_t;

    exp_t       sb[$];
    bit         m_valid [8];
    logic [2:0] m_tag   [8];
    int         m_hit;
    int         m_miss;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hits"},   32'(hit_count),  32'(m_hit));
        check({tag, "_misses"}, 32'(miss_count), 32'(m_miss));
    endtask

    // One fetch: called just after a posedge, returns just after the posedge
    // that consumes the (finally hitting) fetch.
    task automatic fetch(input logic [9:0] a, input bit wiggle);
        logic [2:0] idx;
        bit         hit;
        bit         done;
        int         stall;
        exp_t       e;
        exp_t       got;
        idx     = a[6:4];
        hit     = m_valid[idx] && (m_tag[idx] == a[9:7]);
        e.instr = memword(a[9:4], a[3:2]);
        e.stall = hit ? 0 : mem_lat + 3;
        sb.push_back(e);
        read    = 1'b1;
        address = a;
        stall   = 0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clock);
            if (!busywait) begin
                done = 1'b1;
            end else begin
                stall++;
                if (mem_read)
                    check("mem_address", 32'(mem_address), 32'(a[9:4]));
                if (wiggle && stall == 2) address = a ^ 10'h3F0;
                if (wiggle && stall == 4) address = a;
                if (stall > 60) begin
                    check("stall_timeout", 32'(stall), 32'(e.stall));
                    done = 1'b1;
                end
            end
        end
        got = sb.pop_front();
        check("instruction", instruction, got.instr);
        check("stall_cycles", 32'(stall), 32'(got.stall));
        if (!hit) begin
            m_miss       = sat(m_miss);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[9:7];
        end
        m_hit = sat(m_hit);
        @(posedge clock);
        #1;
        check_counts("fetch");
    endtask

    initial begin
        reset   = 1'b1;
        read    = 1'b0;
        address = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check_counts("rst");

        // Cold miss then same-block hits.
        mem_lat = 0;
        fetch(10'h000, 1'b0);
        fetch(10'h004, 1'b0);
        fetch(10'h008, 1'b0);
        fetch(10'h00C, 1'b0);

        // Conflict on index 1.
        fetch(10'h010, 1'b0);
        fetch(10'h090, 1'b0);
        fetch(10'h010, 1'b0);

        // Slower memories, address wandering during the wait.
        mem_lat = 1;
        fetch(10'h020, 1'b0);
        mem_lat = 5;
        fetch(10'h030, 1'b1);
        fetch(10'h034, 1'b0);

        // Fetch abandoned mid-miss: fill still completes, no hit counted.
        read    = 1'b1;
        address = 10'h148;
        @(negedge clock);
        check("drop_busywait", 32'(busywait), 32'd1);
        @(posedge clock);
        #1;
        read = 1'b0;
        repeat (mem_lat + 4) @(posedge clock);
        #1;
        m_miss     = sat(m_miss);
        m_valid[4] = 1'b1;
        m_tag[4]   = 3'd2;
        check_counts("drop");
        fetch(10'h148, 1'b0);

        // Reset while the memory read is outstanding.
        read    = 1'b1;
        address = 10'h050;
        repeat (3) @(negedge clock);
        check("pre_rst_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_mem_read", 32'(mem_read), 32'd0);
        check("midrst_mem_address", 32'(mem_address), 32'd0);
        model_reset();
        check_counts("midrst");
        read = 1'b0;
        @(negedge clock);
        check("midrst_busywait", 32'(busywait), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (mem_lat + 4) @(posedge clock);
        #1;
        check_counts("after_rst");
        fetch(10'h000, 1'b0);

        // Hit counter saturation.
        for (int i = 0; i < 20; i++)
            fetch(10'(4 * (i % 4)), 1'b0);
        check("sat_hits", 32'(hit_count), 32'(CMAX));

        read = 1'b0;
        @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
